sensor_uart_tx: RTL and testbench

SENSOR_UART_TX -- requirements
Module: sensor_uart_tx

---
 rtl/sensor_pkg.sv | 44 ++++
 rtl/uart_tx_byte.sv | 116 +++++++++++
 rtl/sensor_uart_tx.sv | 117 +++++++++++
 tb/tb_sensor_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// sensor_pkg: shared definitions for the DHT11-to-UART packet transmitter.
//   - packet header default, status codes and packet length
//   - serializer state encoding
//   - DHT11 frame layout and the payload builder (checksum + status decision)
package sensor_pkg;

  localparam logic [7:0] DEFAULT_HEADER  = 8'hAA;
  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_NEG      = 8'h01;
  localparam logic [7:0] STATUS_BAD_CSUM = 8'hE1;
  localparam int         NUM_BYTES       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // DHT11 frame as delivered by the sensor front end, MSB first.
  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tmp_int;
    logic [7:0] tmp_dec;
    logic [7:0] checksum;
  } dht_frame_t;

  // Returns the three bytes that follow the header: {hum, tmp, status}.
  // A bad checksum blanks both data bytes so a receiver never sees
  // corrupted readings, only the error status.
  function automatic logic [23:0] build_payload(input dht_frame_t f);
    logic [7:0]  sum;
    logic [23:0] p;
    sum = f.hum_int + f.hum_dec + f.tmp_int + f.tmp_dec;
    if (sum != f.checksum) begin
      p = {8'h00, 8'h00, STATUS_BAD_CSUM};
    end else begin
      p = {f.hum_int, f.tmp_int, (f.tmp_dec[7] ? STATUS_NEG : STATUS_OK)};
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one byte per start request.
//   i_clk    system clock (rising edge)
//   i_srst   synchronous active-high reset
//   i_start  load i_byte and begin a frame (honoured in IDLE, and in the
//            last cycle of STOP so bytes can run back to back)
//   i_byte   byte to send, LSB first
//   o_tx     registered serial line, idle high
//   o_busy   a frame is in progress
//   o_done   high during the final cycle of the stop bit
module uart_tx_byte
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_tx, w_tx_next;
  logic             w_bit_end;

  assign w_bit_end = (r_clk_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  // tx is computed one cycle ahead so the line itself is a plain flop.
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_next = '0;
        w_tx_next      = 1'b1;
        if (i_start) begin
          w_state_next = ST_START;
          w_shift_next = i_byte;
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = ST_DATA;
          w_tx_next      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = '0;
            w_state_next   = ST_STOP;
            w_tx_next      = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          // Chaining straight into the next start bit leaves no idle gap.
          if (i_start) begin
            w_state_next = ST_START;
            w_shift_next = i_byte;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign o_tx   = r_tx;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_STOP) && w_bit_end;

endmodule

// File: rtl/sensor_uart_tx.sv
// sensor_uart_tx: accepts a 40-bit DHT11 frame and sends a 4-byte UART
// packet {HEADER, hum_int, tmp_int, status}, 8N1, bytes back to back.
//   sys_clk      system clock (rising edge)
//   sys_rst      synchronous active-high reset, aborts any packet
//   frame_valid  a frame is offered on frame_data
//   frame_data   {hum_int, hum_dec, tmp_int, tmp_dec, checksum}
//   frame_ready  registered; high while no packet is in flight
//   tx           registered serial line, idle high
//   drop_cnt     saturating count of cycles with frame_valid while busy
module sensor_uart_tx
  import sensor_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_valid,
  input  logic [39:0] frame_data,
  output logic        frame_ready,
  output logic        tx,
  output logic [7:0]  drop_cnt
);

  localparam int                IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic             r_ready;
  logic [7:0]       r_drop;
  logic [IDX_W-1:0] r_byte_idx;
  logic [7:0]       r_pkt [NUM_BYTES];

  dht_frame_t       w_frame;
  logic [23:0]      w_payload;
  logic [7:0]       w_pkt [NUM_BYTES];
  logic [IDX_W-1:0] w_next_idx;
  logic             w_accept;
  logic             w_more;
  logic             w_ser_start;
  logic [7:0]       w_ser_byte;
  logic             w_ser_tx;
  logic             w_ser_busy;
  logic             w_ser_done;

  assign w_frame   = dht_frame_t'(frame_data);
  assign w_payload = build_payload(w_frame);
  assign w_pkt[0]  = HEADER;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_BYTES; gi++) begin : g_pkt_bytes
      assign w_pkt[gi] = w_payload[8*(NUM_BYTES-1-gi) +: 8];
    end
  endgenerate

  // Frames are only taken when the serializer is truly idle and never
  // while reset is held.
  assign w_accept    = frame_valid && r_ready && !w_ser_busy && !sys_rst;
  assign w_more      = !r_ready && w_ser_done && (r_byte_idx != LAST_IDX);
  assign w_next_idx  = r_byte_idx + 1'b1;
  assign w_ser_start = w_accept || w_more;
  // The header goes out straight from the parameter so the line can drop
  // in the cycle right after acceptance.
  assign w_ser_byte  = w_accept ? HEADER : r_pkt[w_next_idx];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ready    <= 1'b1;
      r_drop     <= '0;
      r_byte_idx <= '0;
    end else begin
      if (frame_valid && !r_ready && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
      if (w_accept) begin
        r_ready    <= 1'b0;
        r_byte_idx <= '0;
      end else if (!r_ready && w_ser_done) begin
        if (r_byte_idx == LAST_IDX) begin
          r_byte_idx <= '0;
          r_ready    <= 1'b1;
        end else begin
          r_byte_idx <= w_next_idx;
        end
      end
    end
  end

  // Packet bytes are captured only on acceptance, so frames offered while
  // busy cannot disturb the packet in flight.
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_pkt_regs
      always_ff @(posedge sys_clk) begin
        if (w_accept) begin
          r_pkt[gi] <= w_pkt[gi];
        end
      end
    end
  endgenerate

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .i_clk  (sys_clk),
    .i_srst (sys_rst),
    .i_start(w_ser_start),
    .i_byte (w_ser_byte),
    .o_tx   (w_ser_tx),
    .o_busy (w_ser_busy),
    .o_done (w_ser_done)
  );

  assign frame_ready = r_ready;
  assign tx          = w_ser_tx;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_sensor_uart_tx.sv
// tb_sensor_uart_tx: directed checks of sensor_uart_tx with CLKS_PER_BIT=4.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Cycle 0 is the acceptance cycle; cycle 1 is the first cycle of the start bit.
module tb_sensor_uart_tx;

  localparam int CPB = 4;
  localparam logic [39:0] F_OK  = 40'h3700190050;
  localparam logic [39:0] F_BAD = 40'h3700190051;
  localparam logic [39:0] F_NEG = 40'h1E00058AAD;
  localparam logic [39:0] F_ALT = 40'h010203040A;
  localparam logic [31:0] P_OK  = 32'hAA371900;
  localparam logic [31:0] P_BAD = 32'hAA0000E1;
  localparam logic [31:0] P_NEG = 32'hAA1E0501;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        frame_valid;
  logic [39:0] frame_data;
  logic        frame_ready;
  logic        tx;
  logic [7:0]  drop_cnt;

  sensor_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hAA)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .frame_ready(frame_ready),
    .tx         (tx),
    .drop_cnt   (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic line_obs [0:399];
  logic line_exp [0:399];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic clear_lines();
    for (int c = 0; c < 400; c++) begin
      line_exp[c] = 1'b1;
      line_obs[c] = 1'b1;
    end
  endtask

  // Expected 8N1 waveform of a packet whose first start bit is at cycle s.
  task automatic put_pkt(input int s, input logic [31:0] bytes);
    logic [7:0] b;
    logic       v;
    for (int k = 0; k < 4; k++) begin
      b = bytes[31-8*k -: 8];
      for (int j = 0; j < 10; j++) begin
        if (j == 0) v = 1'b0;
        else if (j == 9) v = 1'b1;
        else v = b[j-1];
        for (int q = 0; q < CPB; q++) line_exp[s + (k*10 + j)*CPB + q] = v;
      end
    end
  endtask

  // Decode the captured line near each bit's centre.
  task automatic get_pkt(input int s, output logic [31:0] bytes);
    logic [7:0] b;
    bytes = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) b[i] = line_obs[s + (k*10 + 1 + i)*CPB + 1];
      bytes[31-8*k -: 8] = b;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!frame_ready && t < 1000) begin
      @(negedge sys_clk);
      t++;
    end
    if (!frame_ready) check("ready_timeout", 32'(frame_ready), 32'd1);
  endtask

  // Offer frame f for one cycle, capture n cycles of tx; optionally offer
  // inj_data for one cycle starting at cycle inj_at (0 = none).
  task automatic run_pkt(input logic [39:0] f, input int n, input int inj_at,
                         input logic [39:0] inj_data,
                         output int ready_low, output logic last_ready);
    wait_ready();
    frame_data  = f;
    frame_valid = 1'b1;
    ready_low   = 0;
    last_ready  = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge sys_clk);
      line_obs[c] = tx;
      if (!frame_ready) ready_low++;
      last_ready = frame_ready;
      if (c == 1) frame_valid = 1'b0;
      if (c == inj_at) begin
        frame_data  = inj_data;
        frame_valid = 1'b1;
      end else if (c == inj_at + 1) begin
        frame_valid = 1'b0;
      end
    end
    frame_valid = 1'b0;
  endtask

  task automatic check_line(input string tag, input int n);
    int errs = 0;
    for (int c = 1; c <= n; c++) if (line_obs[c] !== line_exp[c]) errs++;
    check({tag, "_line"}, 32'(errs), 32'd0);
  endtask

  task automatic check_bytes(input string tag, input int s, input logic [31:0] exp);
    logic [31:0] got;
    get_pkt(s, got);
    $display("packet %s: bytes %h", tag, got);
    check({tag, "_bytes"}, got, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1);
  end

  initial begin
    int   rl;
    logic lr;
    int   lows;

    sys_rst     = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_tx",    32'(tx),          32'd1);
    check("rst_ready", 32'(frame_ready), 32'd1);
    check("rst_drop",  32'(drop_cnt),    32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Good checksum, positive temperature: 160 low-ready cycles, then ready.
    clear_lines();
    put_pkt(1, P_OK);
    run_pkt(F_OK, 161, 0, '0, rl, lr);
    check_bytes("ok", 1, P_OK);
    check_line("ok", 161);
    check("ok_ready_low",   32'(rl), 32'd160);
    check("ok_ready_after", 32'(lr), 32'd1);

    // Bad checksum: data blanked, error status.
    clear_lines();
    put_pkt(1, P_BAD);
    run_pkt(F_BAD, 161, 0, '0, rl, lr);
    check_bytes("bad", 1, P_BAD);
    check_line("bad", 161);

    // Negative temperature flag from tmp_dec[7].
    clear_lines();
    put_pkt(1, P_NEG);
    run_pkt(F_NEG, 161, 0, '0, rl, lr);
    check_bytes("neg", 1, P_NEG);
    check_line("neg", 161);

    // One-cycle offer 20 cycles into a packet: dropped, packet untouched.
    clear_lines();
    put_pkt(1, P_OK);
    run_pkt(F_OK, 161, 20, F_ALT, rl, lr);
    check_bytes("drop", 1, P_OK);
    check_line("drop", 161);
    check("drop_one", 32'(drop_cnt), 32'd1);

    // Held valid for 300 cycles: far more than 254 busy cycles, so saturate.
    frame_data  = F_OK;
    frame_valid = 1'b1;
    repeat (300) @(negedge sys_clk);
    frame_valid = 1'b0;
    wait_ready();
    $display("saturate: drop_cnt %0d", drop_cnt);
    check("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset at cycle 50 of a packet, with a frame offered during reset.
    wait_ready();
    frame_data  = F_OK;
    frame_valid = 1'b1;
    @(negedge sys_clk);
    frame_valid = 1'b0;
    repeat (49) @(negedge sys_clk);
    sys_rst     = 1'b1;
    frame_valid = 1'b1;
    frame_data  = F_NEG;
    @(negedge sys_clk);
    check("midrst_tx",    32'(tx),          32'd1);
    check("midrst_ready", 32'(frame_ready), 32'd1);
    check("midrst_drop",  32'(drop_cnt),    32'd0);
    sys_rst     = 1'b0;
    frame_valid = 1'b0;
    lows = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      if (!tx) lows++;
    end
    $display("after reset: tx low for %0d cycles", lows);
    check("midrst_aborted", 32'(lows), 32'd0);

    clear_lines();
    put_pkt(1, P_NEG);
    run_pkt(F_NEG, 161, 0, '0, rl, lr);
    check_bytes("post_rst", 1, P_NEG);
    check_line("post_rst", 161);

    // Back to back: second frame offered in cycle 161, the first cycle
    // ready is high again. Its start bit begins at cycle 162, so the line
    // carries 80 bit times with only the hand-off cycle between packets.
    clear_lines();
    put_pkt(1, P_OK);
    put_pkt(162, P_NEG);
    run_pkt(F_OK, 321, 161, F_NEG, rl, lr);
    check_bytes("b2b_first", 1, P_OK);
    check_bytes("b2b_second", 162, P_NEG);
    check_line("b2b", 321);
    check("b2b_start_bit", 32'(line_obs[162]), 32'd0);
    check("b2b_ready_low", 32'(rl), 32'd320);
    check("b2b_no_drop",   32'(drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
